fp_muldiv_seq: RTL and testbench
================================

# fp_muldiv_seq

Parametrised, sequential IEEE-754-style floating-point multiply/divide unit: the next generation of `mul_div`. It generalises operand format through `EXP_W`/`MAN_W` and replaces free-running operation with valid/ready handshakes on both sides. It uses an iterative shift-add multiplier and a restoring divider, followed by round-to-nearest-even. It sits between the operand sequencer and the result writeback stage, and reports the same five exception flags as `mul_div`.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored fraction width. Total width `W = 1 + EXP_W + MAN_W`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `arst` input 1: reset; synchronous, active-high.
- `en` input 1: global stall; when 0, all state and outputs hold.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: high only in IDLE.
- `a`, `b` input W: operands; `a` is the dividend for divide.
- `sel` input 1: 0 = a×b, 1 = a÷b.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer accepts result.
- `R` output W: result.
- `io_flag`, `dz_flag`, `of_flag`, `uf_flag`, `i_flag` output 1 each: invalid, divide-by-zero, overflow, underflow, inexact.

## Operation
- States:
  - IDLE: `in_valid`&&`en` → UNPACK. Latches `a`, `b` and `sel`.
  - UNPACK: classifies the operands. A special case → DONE; otherwise → ITER and loads the counter.
  - ITER: runs for N cycles, with N = `MAN_W+1` for multiply and N = `MAN_W+3` for divide. → ROUND when the counter reaches 0.
  - ROUND: → DONE.
  - DONE: `out_ready`&&`en` → IDLE.
- Subnormal inputs are treated as signed zero (flush-to-zero). Exponents are computed in `EXP_W+2`-bit signed arithmetic, so intermediate values never wrap.
- Multiply: `(MAN_W+1)×(MAN_W+1)` shift-add; one bit per ITER cycle; product `2*MAN_W+2` bits.
- Divide: restoring division, one quotient bit per cycle. It produces `MAN_W+3` quotient bits; a nonzero remainder ORs into sticky.
- ROUND:
  - Normalise by at most 1 bit.
  - Round to nearest, ties to even, using guard/round/sticky.
  - A mantissa carry-out increments the exponent.
  - `i_flag` = any discarded bit nonzero.
- Result sign = `a[W-1]^b[W-1]`, including zero and infinity results.
- Overflow (biased exponent ≥ all-ones): `R` = ±inf, `of_flag`=1, `i_flag`=1.
- Underflow (rounded result below minimum normal): `R` = ±0, `uf_flag`=1, `i_flag`=1.
- Special cases, resolved in UNPACK:
  - Any NaN input → canonical quiet NaN `{0, all-ones exponent, 1, zeros}`. `io_flag`=1 if any input is signaling (fraction MSB = 0).
  - 0×inf, 0/0, inf/inf → qNaN, `io_flag`=1.
  - finite nonzero / 0 → ±inf, `dz_flag`=1.
  - inf × nonzero, inf/finite → ±inf.
  - x/inf (x finite) and 0×finite → ±0.
  - No flags are raised in the last two cases.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `R`=0, all flags 0.
- Reset mid-operation discards the operation. From the next cycle the block is in IDLE with `out_valid`=0.
- Latency is counted in rising edges from the accept edge to the first cycle `out_valid`=1, with `en` held high:
  - multiply: `MAN_W+4` (27 for defaults);
  - divide: `MAN_W+6` (29 for defaults);
  - special case: 2.
- An edge with `en`=0 does not count toward latency.
- `R` and the flags are registered. They are stable from the rising edge of `out_valid` until the handshake completes, and do not change while `out_valid`&&!`out_ready`.
- `in_ready` is 0 from UNPACK through DONE. A new operand is accepted at the earliest one cycle after the output handshake, so there is one operation in flight at most.
- `in_valid` while busy is ignored and not queued.
- `arst` takes priority over `en`.

## Test plan
- Normal multiply, FP32: a=0x40400000, b=0x40200000, sel=0 → R=0x40F00000, all flags 0, `out_valid` 27 edges after accept.
- Inexact divide: a=0x3F800000, b=0x40400000, sel=1 → R=0x3EAAAAAB, `i_flag`=1, other flags 0, latency 29.
- Specials:
  - a=0x3F800000, b=0 → R=0x7F800000, `dz_flag`=1, latency 2.
  - a=0, b=0x7F800000, sel=0 → R=0x7FC00000, `io_flag`=1.
  - a=0x7F800001 → R=0x7FC00000, `io_flag`=1.
- Range limits:
  - a=0x7F000000, b=0x40000000, mul → R=0x7F800000, `of_flag`=`i_flag`=1.
  - a=0x00800000, b=0x3F000000, mul → R=0x00000000, `uf_flag`=`i_flag`=1.
- Back-pressure and stall:
  - Hold `out_ready`=0 for 10 cycles → R and flags unchanged, `in_ready`=0.
  - Drop `en` for 5 cycles mid-ITER → latency grows by exactly 5.
- Reset mid-ITER: assert `arst` at edge 10 of a divide. Next cycle → `in_ready`=1, `out_valid`=0, R=0. A following 2.0×2.0 (0x40000000×0x40000000) → 0x40800000.

Source files
------------

// File: rtl/fp_muldiv_seq.sv
// Sequential floating-point multiply/divide: shift-add multiplier, restoring divider,
// round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_muldiv_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   R,
    output logic                   io_flag,
    output logic                   dz_flag,
    output logic                   of_flag,
    output logic                   uf_flag,
    output logic                   i_flag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 3) + 1;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          r_q, r_d;
    logic [4:0]            flags_q, flags_d;   // {io, dz, of, uf, i}
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic                  sel_q, sel_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [P-1:0]          mcand_q, mcand_d, acc_q, acc_d;
    logic [MAN_W:0]        mplier_q, mplier_d;
    logic [MAN_W+1:0]      rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Operand classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb, res_sign;
    logic signed [EW-1:0] ea_s, eb_s;
    logic [W-1:0]     inf_r, zero_r;

    assign ea       = a_q[W-2:MAN_W];
    assign eb       = b_q[W-2:MAN_W];
    assign fa       = a_q[MAN_W-1:0];
    assign fb       = b_q[MAN_W-1:0];
    assign za       = (ea == '0);
    assign zb       = (eb == '0);
    assign ia       = (&ea) && (fa == '0);
    assign ib       = (&eb) && (fb == '0);
    assign na       = (&ea) && (fa != '0);
    assign nb       = (&eb) && (fb != '0);
    assign res_sign = a_q[W-1] ^ b_q[W-1];
    assign ea_s     = $signed({2'b00, ea});
    assign eb_s     = $signed({2'b00, eb});
    assign inf_r    = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_r   = {res_sign, {(W-1){1'b0}}};

    logic         special;
    logic [W-1:0] spec_r;
    logic [4:0]   spec_fl;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        special = 1'b1;
        spec_r  = zero_r;
        spec_fl = 5'b00000;
        if (na || nb) begin
            spec_r     = QNAN;
            spec_fl[4] = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);
        end else if (!sel_q) begin
            if ((za && ib) || (ia && zb)) begin
                spec_r  = QNAN;
                spec_fl = 5'b10000;
            end else if (ia || ib) spec_r = inf_r;
            else if (za || zb)     spec_r = zero_r;
            else                   special = 1'b0;
        end else begin
            if ((za && zb) || (ia && ib)) begin
                spec_r  = QNAN;
                spec_fl = 5'b10000;
            end else if (ia) spec_r = inf_r;
            else if (zb) begin
                spec_r  = inf_r;
                spec_fl = 5'b01000;
            end else if (ib || za) spec_r = zero_r;
            else                   special = 1'b0;
        end
    end

    // Normalise by at most one bit, then round to nearest even
    logic [P-1:0]         mul_norm;
    logic [MAN_W+2:0]     quo, div_norm;
    logic [MAN_W:0]       mant;
    logic                 guard, sticky;
    logic signed [EW-1:0] exp_adj, exp_rnd;
    logic [MAN_W+1:0]     mant_rnd;
    logic [MAN_W-1:0]     frac_rnd;

    always_comb begin
        quo      = acc_q[MAN_W+2:0];
        mul_norm = acc_q[P-1] ? acc_q : (acc_q << 1);
        div_norm = quo[MAN_W+2] ? quo : (quo << 1);
        mant     = mul_norm[P-1:MAN_W+1];
        guard    = mul_norm[MAN_W];
        sticky   = |mul_norm[MAN_W-1:0];
        exp_adj  = acc_q[P-1] ? exp_q + ONE : exp_q;
        if (sel_q) begin
            mant    = div_norm[MAN_W+2:2];
            guard   = div_norm[1];
            sticky  = div_norm[0] | (rem_q != '0);
            exp_adj = quo[MAN_W+2] ? exp_q : exp_q - ONE;
        end
        mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, guard & (mant[0] | sticky)};
        exp_rnd  = mant_rnd[MAN_W+1] ? exp_adj + ONE : exp_adj;
        frac_rnd = mant_rnd[MAN_W+1] ? '0 : mant_rnd[MAN_W-1:0];
    end

    // Restoring divide step: divisor sits in the low bits of mcand
    logic                 div_ge;
    logic [MAN_W+1:0]     rem_sub;
    assign div_ge  = (rem_q >= {1'b0, mcand_q[MAN_W:0]});
    assign rem_sub = div_ge ? rem_q - {1'b0, mcand_q[MAN_W:0]} : rem_q;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        flags_d  = flags_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                sel_d   = sel;
                state_d = S_UNPACK;
            end
            S_UNPACK: if (special) begin
                r_d     = spec_r;
                flags_d = spec_fl;
                state_d = S_DONE;
            end else begin
                exp_d    = sel_q ? ea_s - eb_s + BIAS : ea_s + eb_s - BIAS;
                mcand_d  = {{(P-MAN_W-1){1'b0}}, 1'b1, sel_q ? fb : fa};
                mplier_d = {1'b1, fb};
                acc_d    = '0;
                rem_d    = {2'b01, fa};
                cnt_d    = sel_q ? CW'(MAN_W + 2) : CW'(MAN_W);
                state_d  = S_ITER;
            end
            S_ITER: begin
                if (sel_q) begin
                    acc_d = {acc_q[P-2:0], div_ge};
                    rem_d = {rem_sub[MAN_W:0], 1'b0};
                end else begin
                    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == '0) state_d = S_ROUND;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ROUND: begin
                if (exp_rnd >= EMAX) begin
                    r_d     = inf_r;
                    flags_d = 5'b00101;
                end else if (exp_rnd < ONE) begin
                    r_d     = zero_r;
                    flags_d = 5'b00011;
                end else begin
                    r_d     = {res_sign, exp_rnd[EXP_W-1:0], frac_rnd};
                    flags_d = {4'b0000, guard | sticky};
                end
                state_d = S_DONE;
            end
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            flags_q     <= '0;
        end else if (en) begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            flags_q     <= flags_d;
        end
    end

    // NOTE: datapath registers have no reset; each is loaded in IDLE/UNPACK before it is read.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign {io_flag, dz_flag, of_flag, uf_flag, i_flag} = flags_q;

endmodule

// File: tb/tb_fp_muldiv_seq.sv
// Self-checking bench for fp_muldiv_seq (FP32 defaults): directed vectors, random
// operands against an exact-integer reference model, back-pressure, stall and reset.
module tb_fp_muldiv_seq;

    logic        clk, arst, en, in_valid, in_ready, sel, out_valid, out_ready;
    logic [31:0] a, b, R;
    logic        io_flag, dz_flag, of_flag, uf_flag, i_flag;
    logic [4:0]  flags_o;

    int errors = 0;
    int checks = 0;

    assign flags_o = {io_flag, dz_flag, of_flag, uf_flag, i_flag};

    fp_muldiv_seq dut (
        .clk(clk), .arst(arst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .io_flag(io_flag), .dz_flag(dz_flag), .of_flag(of_flag),
        .uf_flag(uf_flag), .i_flag(i_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer significand product/quotient, rounded from the leading one.
    function automatic void ref_model(input logic [31:0] x, input logic [31:0] y, input logic op,
                                      output logic [31:0] r, output logic [4:0] fl, output bit spec);
        int ex, ey, p, k, e, sh;
        logic [22:0] fx, fy;
        logic s;
        bit zx, zy, ix, iy, nx, ny;
        longint unsigned mx, my, n, kept, remv, half;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        fx = x[22:0];        fy = y[22:0];
        s  = x[31] ^ y[31];
        zx = (ex == 0); zy = (ey == 0);
        ix = (ex == 255) && (fx == 0); iy = (ey == 255) && (fy == 0);
        nx = (ex == 255) && (fx != 0); ny = (ey == 255) && (fy != 0);
        fl = 5'b00000; spec = 1; r = {s, 31'h0};
        if (nx || ny) begin
            r = 32'h7FC00000;
            fl[4] = (nx && !fx[22]) || (ny && !fy[22]);
        end else if (!op) begin
            if ((zx && iy) || (ix && zy)) begin r = 32'h7FC00000; fl = 5'b10000; end
            else if (ix || iy)            r = {s, 8'hFF, 23'h0};
            else if (zx || zy)            r = {s, 31'h0};
            else                          spec = 0;
        end else begin
            if ((zx && zy) || (ix && iy)) begin r = 32'h7FC00000; fl = 5'b10000; end
            else if (ix)                  r = {s, 8'hFF, 23'h0};
            else if (zy) begin            r = {s, 8'hFF, 23'h0}; fl = 5'b01000; end
            else if (iy || zx)            r = {s, 31'h0};
            else                          spec = 0;
        end
        if (!spec) begin
            mx = {40'h0, 1'b1, fx};
            my = {40'h0, 1'b1, fy};
            if (!op) begin
                n = mx * my;
                k = ex + ey - 254 - 46;
            end else begin
                n = (((mx << 38) / my) << 1) | longint'(((mx << 38) % my) != 0);
                k = ex - ey - 39;
            end
            p = 63;
            while (!n[p]) p--;
            sh   = p - 23;
            kept = n >> sh;
            remv = n & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (remv > half || (remv == half && kept[0])) kept++;
            e = p + k + 127;
            if (kept == (64'd1 << 24)) begin kept = kept >> 1; e++; end
            if (e >= 255)    begin r = {s, 8'hFF, 23'h0}; fl = 5'b00101; end
            else if (e <= 0) begin r = {s, 31'h0};        fl = 5'b00011; end
            else begin
                r  = {s, 8'(e), kept[22:0]};
                fl = {4'b0000, remv != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int          kind;
        logic [7:0]  e;
        logic [22:0] f;
        kind = $urandom_range(0, 9);
        f    = 23'($urandom);
        case (kind)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
            2:       e = 8'($urandom_range(1, 10));
            3:       e = 8'($urandom_range(245, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic op);
        in_valid = 1'b1; a = x; b = y; sel = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge; en is dropped for stall_len edges after edge stall_at.
    task automatic wait_out(input int stall_at, input int stall_len, output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            en = !(lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        en = 1'b1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (R !== 32'h0) begin errors++; $display("FAIL reset_R got=%h want=00000000", R); end
        checks++; if (flags_o !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b want=00000", flags_o); end
        en = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] r;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[7];
        int   lat;
        vecs[0] = '{32'h40400000, 32'h40200000, 1'b0, 32'h40F00000, 5'b00000, 27};
        vecs[1] = '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 5'b00001, 29};
        vecs[2] = '{32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 5'b01000, 2};
        vecs[3] = '{32'h00000000, 32'h7F800000, 1'b0, 32'h7FC00000, 5'b10000, 2};
        vecs[4] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000, 2};
        vecs[5] = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 5'b00101, 27};
        vecs[6] = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 5'b00011, 27};
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            wait_out(0, 0, lat);
            checks++; if (R !== vecs[i].r) begin errors++; $display("FAIL directed%0d_R got=%h want=%h", i, R, vecs[i].r); end
            checks++; if (flags_o !== vecs[i].fl) begin errors++; $display("FAIL directed%0d_flags got=%b want=%b", i, flags_o, vecs[i].fl); end
            checks++; if (lat !== vecs[i].lat) begin errors++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, vecs[i].lat); end
            finish_op();
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] x, y, er;
        logic [4:0]  efl;
        logic        op;
        bit          spec;
        int          lat, elat;
        for (int i = 0; i < n; i++) begin
            x  = rand_op();
            y  = rand_op();
            op = 1'($urandom);
            ref_model(x, y, op, er, efl, spec);
            elat = spec ? 2 : (op ? 29 : 27);
            start_op(x, y, op);
            wait_out(0, 0, lat);
            checks++; if (R !== er) begin errors++; $display("FAIL random_R a=%h b=%h sel=%b got=%h want=%h", x, y, op, R, er); end
            checks++; if (flags_o !== efl) begin errors++; $display("FAIL random_flags a=%h b=%h sel=%b got=%b want=%b", x, y, op, flags_o, efl); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL random_latency a=%h b=%h sel=%b got=%0d want=%0d", x, y, op, lat, elat); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'h3F800000, 32'h40400000, 1'b1);
        wait_out(0, 0, lat);
        checks++; if (R !== 32'h3EAAAAAB) begin errors++; $display("FAIL bp_R got=%h want=3eaaaaab", R); end
        in_valid = 1'b1; a = 32'h40000000; b = 32'h40000000; sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (R !== 32'h3EAAAAAB || flags_o !== 5'b00001 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got R=%h fl=%b ov=%b ir=%b want R=3eaaaaab fl=00001 ov=1 ir=0",
                         i, R, flags_o, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    endtask

    task automatic test_stall();
        int lat;
        start_op(32'h40400000, 32'h40200000, 1'b0);
        wait_out(5, 5, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL stall_latency got=%0d want=32", lat); end
        checks++; if (R !== 32'h40F00000) begin errors++; $display("FAIL stall_R got=%h want=40f00000", R); end
        finish_op();
    endtask

    task automatic test_reset_mid_iter();
        int lat;
        start_op(32'h3F800000, 32'h40400000, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        checks++; if (R !== 32'h0) begin errors++; $display("FAIL rst_mid_R got=%h want=00000000", R); end
        start_op(32'h40000000, 32'h40000000, 1'b0);
        wait_out(0, 0, lat);
        checks++; if (R !== 32'h40800000 || flags_o !== 5'b0) begin errors++; $display("FAIL rst_mid_after got R=%h fl=%b want R=40800000 fl=00000", R, flags_o); end
        checks++; if (lat !== 27) begin errors++; $display("FAIL rst_mid_latency got=%0d want=27", lat); end
        finish_op();
    endtask

    // Second operand pair is presented while busy; it must be taken only after the handshake.
    task automatic test_back_to_back();
        int lat;
        in_valid = 1'b1; a = 32'h40400000; b = 32'h3FC00000; sel = 1'b0;
        @(posedge clk); #1;
        a = 32'h41200000; b = 32'h40000000; sel = 1'b1;
        wait_out(0, 0, lat);
        checks++; if (R !== 32'h40900000 || lat !== 27) begin errors++; $display("FAIL b2b_first got R=%h lat=%0d want R=40900000 lat=27", R, lat); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(0, 0, lat);
        checks++; if (R !== 32'h40A00000 || lat !== 29) begin errors++; $display("FAIL b2b_second got R=%h lat=%0d want R=40a00000 lat=29", R, lat); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300);
        test_backpressure();
        test_stall();
        test_reset_mid_iter();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
